ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares a single-port RAM between three requesters (0 = init,
// 1 = transaction store, 2 = money display). Each granted access takes the
// same four-cycle path, whether it is a read or a write:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE
//
// Arbitration happens on an IDLE edge. The search is round-robin and starts
// just after the last owner. The winner's write enable, word select and
// write data are latched at that edge, so the requester may change them
// afterwards without effect. The ack pulse is registered out of DONE, so it
// is seen in the IDLE cycle that follows. grant stays on the owner through
// that cycle. The next arbitration can therefore hand the RAM straight to
// the next requester, with no gap in grant.
//
// Ports
//   clock            : single clock, rising edge
//   reset            : asynchronous, active-high
//   req[2:0]         : per-requester request
//   req_wren[2:0]    : per-requester write enable (1 = write)
//   req_access_type  : per-requester RAM word select (one bit each)
//   req_data0..2     : per-requester write data
//   ram_result       : RAM read data, valid one cycle after the address
//   ram_wren         : RAM write enable, only ever high in ISSUE
//   ram_access_type  : RAM word select (latched value of the owner)
//   ram_data_in      : RAM write data (latched value of the owner)
//   grant[2:0]       : one-hot owner, zero when idle
//   ack[2:0]         : one-cycle completion pulse to the owner
//   rd_data          : last captured read data
//   busy             : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DATA_W = 48
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        req_wren,
    input  logic [2:0]        req_access_type,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] ram_result,
    output logic              ram_wren,
    output logic              ram_access_type,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [2:0]        grant,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        ack_q, ack_d;
    logic              lat_wren_q, lat_wren_d;
    logic              lat_access_q, lat_access_d;
    logic [DATA_W-1:0] lat_data_q, lat_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // (base + off) mod 3. base is at most 2 and off at most 3, so one
    // conditional subtraction is enough.
    function automatic logic [1:0] rr_index(input logic [1:0] base,
                                            input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Round-robin winner search: slot 0 has the highest priority.
    // Slot k examines requester (last + k + 1) mod 3.
    // ------------------------------------------------------------------
    logic [1:0] cand_idx [3];
    logic       win_found;
    logic [1:0] win_idx;
    logic [2:0] win_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            assign cand_idx[gi]   = rr_index(last_q, 2'(gi + 1));
            assign win_onehot[gi] = win_found && (win_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = 2; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    // Select the winner's fields.
    logic              win_wren;
    logic              win_access;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        win_wren   = 1'b0;
        win_access = 1'b0;
        win_data   = '0;
        case (win_idx)
            2'd0: begin
                win_wren   = req_wren[0];
                win_access = req_access_type[0];
                win_data   = req_data0;
            end
            2'd1: begin
                win_wren   = req_wren[1];
                win_access = req_access_type[1];
                win_data   = req_data1;
            end
            2'd2: begin
                win_wren   = req_wren[2];
                win_access = req_access_type[2];
                win_data   = req_data2;
            end
            default: begin
                win_wren   = 1'b0;
                win_access = 1'b0;
                win_data   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= 2'd2;   // requester 0 wins first after reset
            grant_q      <= 3'b000;
            ack_q        <= 3'b000;
            lat_wren_q   <= 1'b0;
            lat_access_q <= 1'b0;
            lat_data_q   <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            lat_wren_q   <= lat_wren_d;
            lat_access_q <= lat_access_d;
            lat_data_q   <= lat_data_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: fixed sequence, no state ever skipped
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = win_found ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        last_d       = last_q;
        grant_d      = grant_q;
        ack_d        = 3'b000;
        lat_wren_d   = lat_wren_q;
        lat_access_d = lat_access_q;
        lat_data_d   = lat_data_q;
        rd_data_d    = rd_data_q;
        case (state_q)
            S_IDLE: begin
                // grant was left on the previous owner for its ack cycle.
                // Replace it with the new winner, or clear it.
                grant_d = win_onehot;
                if (win_found) begin
                    last_d       = win_idx;
                    lat_wren_d   = win_wren;
                    lat_access_d = win_access;
                    lat_data_d   = win_data;
                end
            end
            S_DONE: begin
                ack_d = grant_q;
                if (!lat_wren_q) begin
                    rd_data_d = ram_result;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ram_wren        = (state_q == S_ISSUE) && lat_wren_q;
        ram_access_type = lat_access_q;
        ram_data_in     = lat_data_q;
        grant           = grant_q;
        ack             = ack_q;
        rd_data         = rd_data_q;
        busy            = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int DW = 48;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    req, req_wren, req_access_type;
    logic [DW-1:0] req_data0, req_data1, req_data2, ram_result;
    logic          ram_wren, ram_access_type, busy;
    logic [DW-1:0] ram_data_in, rd_data;
    logic [2:0]    grant, ack;

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] D0 = 48'h0A0A0A0A0A0A;
    localparam logic [DW-1:0] D1 = 48'h123456789ABC;
    localparam logic [DW-1:0] D2 = 48'h222222222222;

    ram_arbiter #(.DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_wren(req_wren),
        .req_access_type(req_access_type), .req_data0(req_data0),
        .req_data1(req_data1), .req_data2(req_data2), .ram_result(ram_result),
        .ram_wren(ram_wren), .ram_access_type(ram_access_type),
        .ram_data_in(ram_data_in), .grant(grant), .ack(ack),
        .rd_data(rd_data), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    req;
        logic [2:0]    wren;
        logic [2:0]    acc;
        logic [DW-1:0] rres;
        logic [2:0]    e_grant;
        logic [2:0]    e_ack;
        logic          e_wren;
        logic          e_acc;
        logic          e_busy;
        logic [DW-1:0] e_din;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock, then settle past the edge before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " grant"}, 64'(grant), 64'(3'b000));
        chk({tag, " ack"}, 64'(ack), 64'(3'b000));
        chk({tag, " ram_wren"}, 64'(ram_wren), 64'(1'b0));
        chk({tag, " ram_acc"}, 64'(ram_access_type), 64'(1'b0));
        chk({tag, " ram_din"}, 64'(ram_data_in), 64'(0));
        chk({tag, " rd_data"}, 64'(rd_data), 64'(0));
        chk({tag, " busy"}, 64'(busy), 64'(1'b0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
    endtask

    logic [2:0] order [3];
    logic [2:0] exp_g;

    initial begin
        // Single read by requester 2, then single write by requester 1.
        //             req     wren    acc     rres     grant   ack     wr    acc   busy  din rd
        tbl[0] = '{3'b100, 3'b000, 3'b100, 48'hABCD, 3'b100, 3'b000, 1'b0, 1'b1, 1'b1, D2, 48'h0};
        tbl[1] = '{3'b100, 3'b000, 3'b100, 48'hABCD, 3'b100, 3'b000, 1'b0, 1'b1, 1'b1, D2, 48'h0};
        tbl[2] = '{3'b100, 3'b000, 3'b100, 48'hABCD, 3'b100, 3'b000, 1'b0, 1'b1, 1'b1, D2, 48'h0};
        tbl[3] = '{3'b100, 3'b000, 3'b100, 48'hABCD, 3'b100, 3'b100, 1'b0, 1'b1, 1'b0, D2, 48'hABCD};
        tbl[4] = '{3'b000, 3'b000, 3'b000, 48'hABCD, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, D2, 48'hABCD};
        tbl[5] = '{3'b010, 3'b010, 3'b000, 48'hFFFF0000FFFF, 3'b010, 3'b000, 1'b1, 1'b0, 1'b1, D1, 48'hABCD};
        tbl[6] = '{3'b010, 3'b010, 3'b000, 48'hFFFF0000FFFF, 3'b010, 3'b000, 1'b0, 1'b0, 1'b1, D1, 48'hABCD};
        tbl[7] = '{3'b010, 3'b010, 3'b000, 48'hFFFF0000FFFF, 3'b010, 3'b000, 1'b0, 1'b0, 1'b1, D1, 48'hABCD};
        tbl[8] = '{3'b010, 3'b010, 3'b000, 48'hFFFF0000FFFF, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, D1, 48'hABCD};
        tbl[9] = '{3'b000, 3'b000, 3'b000, 48'hFFFF0000FFFF, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, D1, 48'hABCD};

        req = 3'b000; req_wren = 3'b000; req_access_type = 3'b000;
        req_data0 = D0; req_data1 = D1; req_data2 = D2; ram_result = '0;
        reset = 1'b1;
        #2;
        check_reset_values("reset_async");
        step();
        step();
        check_reset_values("reset_held");
        reset = 1'b0;
        step();
        check_reset_values("idle_after_reset");

        // ---------------- table-driven single read / write ----------------
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; req_wren = tbl[i].wren;
            req_access_type = tbl[i].acc; ram_result = tbl[i].rres;
            step();
            chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].e_grant));
            chk($sformatf("vec%0d ack", i), 64'(ack), 64'(tbl[i].e_ack));
            chk($sformatf("vec%0d ram_wren", i), 64'(ram_wren), 64'(tbl[i].e_wren));
            chk($sformatf("vec%0d ram_acc", i), 64'(ram_access_type), 64'(tbl[i].e_acc));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d ram_din", i), 64'(ram_data_in), 64'(tbl[i].e_din));
            chk($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(tbl[i].e_rd));
            $display("vec %0d: req=%b grant=%b ack=%b ram_wren=%b busy=%b",
                     i, tbl[i].req, grant, ack, ram_wren, busy);
        end

        // ---------------- contention: 111, drop on own ack ----------------
        do_reset();
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
        req = 3'b111; req_wren = 3'b000; ram_result = 48'h1111;
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("cont g%0d c%0d grant", g, c), 64'(grant), 64'(order[g]));
                exp_g = (c == 3) ? order[g] : 3'b000;
                chk($sformatf("cont g%0d c%0d ack", g, c), 64'(ack), 64'(exp_g));
                if (c == 3) begin
                    req = req & ~order[g];
                end
            end
            $display("contention grant %0d: grant=%b", g, order[g]);
        end
        step();
        chk("cont final grant", 64'(grant), 64'(3'b000));

        // ---------------- fairness: req[1], req[2] held ----------------
        do_reset();
        req = 3'b110; ram_result = 48'h5A5A5A5A5A5A;
        for (int t = 0; t < 8; t++) begin
            exp_g = (t % 2 == 0) ? 3'b010 : 3'b100;
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("fair t%0d c%0d grant", t, c), 64'(grant), 64'(exp_g));
                if (c == 3) begin
                    chk($sformatf("fair t%0d ack", t), 64'(ack), 64'(exp_g));
                end
            end
            $display("fairness txn %0d: grant=%b", t, exp_g);
        end
        req = 3'b000;
        step();
        chk("fair rd_data", 64'(rd_data), 64'(48'h5A5A5A5A5A5A));

        // ---------------- reset during WAIT of a write ----------------
        req = 3'b001; req_wren = 3'b001; req_data0 = D0;
        step();
        chk("rstw issue wren", 64'(ram_wren), 64'(1'b1));
        chk("rstw issue din", 64'(ram_data_in), 64'(D0));
        step();
        chk("rstw wait busy", 64'(busy), 64'(1'b1));
        reset = 1'b1;
        #1;
        check_reset_values("rstw immediate");
        req = 3'b000; req_wren = 3'b000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstw held c%0d ack", c), 64'(ack), 64'(3'b000));
        end
        reset = 1'b0;
        // Both 0 and 1 ask; a fresh last pointer must favour 0.
        req = 3'b011;
        step();
        chk("rstw first grant", 64'(grant), 64'(3'b001));
        $display("reset during write: post-release grant=%b", grant);
        step(); step(); step();
        chk("rstw ack", 64'(ack), 64'(3'b001));
        req = 3'b000;
        step();

        // ---------------- early drop, fields changed after grant ----------------
        req = 3'b001; req_wren = 3'b000; req_access_type = 3'b001;
        ram_result = 48'h000000000777;
        step();
        chk("drop issue grant", 64'(grant), 64'(3'b001));
        chk("drop issue acc", 64'(ram_access_type), 64'(1'b1));
        req = 3'b000; req_access_type = 3'b000; req_data0 = 48'hDEAD;
        step();
        chk("drop wait acc", 64'(ram_access_type), 64'(1'b1));
        chk("drop wait din", 64'(ram_data_in), 64'(D0));
        step();
        chk("drop done ack", 64'(ack), 64'(3'b000));
        step();
        chk("drop ack", 64'(ack), 64'(3'b001));
        chk("drop rd_data", 64'(rd_data), 64'(48'h777));
        step();
        chk("drop idle grant", 64'(grant), 64'(3'b000));
        chk("drop idle busy", 64'(busy), 64'(1'b0));
        chk("drop idle ack", 64'(ack), 64'(3'b000));
        $display("early drop: ack seen, grant back to %b", grant);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
